// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract sequencer: operand width, FSM states
// and requester ids.
package addsub_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer remembers the last grantee and
// only moves when the parent reports an accept.
module rr_arbiter2
    import addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q, last_d;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == REQ1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        last_d = accept ? grant[1] : last_q;
    end

    // Reset to REQ1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/addsub_sequencer.sv
// Shares one 8-bit add/subtract datapath between two requesters, sequencing
// each operation through complement and add stages before returning a result.
module addsub_sequencer
    import addsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             req1_ready,
    output logic [WIDTH-1:0] tc_in,
    input  logic [WIDTH-1:0] tc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_ovf,
    output logic             res_cy,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, beff_q, beff_d, data_q, data_d;
    logic             sub_q, sub_d, id_q, id_d, ovf_q, ovf_d, cy_q, cy_d;
    logic [1:0]       grant;
    logic             in_idle, accept;
    logic [WIDTH:0]   sum;

    // Gating with rst_n keeps both readies low while reset is held.
    assign in_idle    = (state_q == IDLE) && rst_n;
    assign accept     = in_idle && (req0_valid || req1_valid);
    assign req0_ready = in_idle && grant[0];
    assign req1_ready = in_idle && grant[1];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        beff_d  = beff_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        cy_d    = cy_q;
        tc_in   = '0;
        sum     = {1'b0, a_q} + {1'b0, beff_q};
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant[1] ? req1_a   : req0_a;
                    b_d     = grant[1] ? req1_b   : req0_b;
                    sub_d   = grant[1] ? req1_sub : req0_sub;
                    id_d    = grant[1] ? REQ1     : REQ0;
                    state_d = COMP;
                end
            end
            COMP: begin
                tc_in   = b_q;
                beff_d  = sub_q ? tc_out : b_q;
                state_d = ADD;
            end
            ADD: begin
                data_d = sum[WIDTH-1:0];
                // Subtract overflow uses the original B so B = 0x80 is handled.
                if (sub_q) begin
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                    cy_d  = (a_q < b_q);
                end else begin
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                    cy_d  = sum[WIDTH];
                end
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            beff_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            beff_q  <= beff_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            cy_q    <= cy_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_ovf   = ovf_q;
    assign res_cy    = cy_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: an operation-level model checked every cycle plus
// directed vectors with hand-computed results.
module tb_addsub_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_sub = 1'b0, req1_sub = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] tc_in, tc_out;
    logic       res_valid, res_id, res_ovf, res_cy, busy;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Operation-level model state: age counts cycles since the accept.
    bit m_busy = 1'b0;
    int m_age, m_a, m_b, m_sub, m_id;
    int m_last = 1;

    int dut_ids[$];
    int dut_cycs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External two's-complement unit.
    assign tc_out = ~tc_in + 8'd1;

    addsub_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .req1_ready (req1_ready),
        .tc_in      (tc_in),
        .tc_out     (tc_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf),
        .res_cy     (res_cy),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void arith(input int a, input int b, input int sub,
                                  output int data, output int ovf, output int cy);
        int sa, sb, r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r  = sub ? sa - sb : sa + sb;
        ovf  = (r > 127 || r < -128) ? 1 : 0;
        data = (sub ? a - b : a + b) & 255;
        cy   = sub ? ((a < b) ? 1 : 0) : ((a + b > 255) ? 1 : 0);
    endfunction

    // Compare process: checks every cycle at the falling edge, then advances the
    // model across the coming rising edge.
    always @(negedge clk) begin
        int e_r0, e_r1, e_d, e_o, e_c;
        if (req0_ready || req1_ready) begin
            dut_ids.push_back(req1_ready ? 1 : 0);
            dut_cycs.push_back(cyc);
        end
        if (!rst_n) begin
            chk("rst req0_ready", int'(req0_ready), 0);
            chk("rst req1_ready", int'(req1_ready), 0);
            chk("rst res_valid", int'(res_valid), 0);
            chk("rst res_data", int'(res_data), 0);
            chk("rst res_id", int'(res_id), 0);
            chk("rst res_ovf", int'(res_ovf), 0);
            chk("rst res_cy", int'(res_cy), 0);
            chk("rst busy", int'(busy), 0);
            chk("rst tc_in", int'(tc_in), 0);
            m_busy = 1'b0;
            m_last = 1;
        end else begin
            e_r0 = 0;
            e_r1 = 0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    if (m_last == 1) e_r0 = 1; else e_r1 = 1;
                end else begin
                    e_r0 = int'(req0_valid);
                    e_r1 = int'(req1_valid);
                end
            end
            chk("req0_ready", int'(req0_ready), e_r0);
            chk("req1_ready", int'(req1_ready), e_r1);
            chk("busy", int'(busy), int'(m_busy));
            chk("tc_in", int'(tc_in), (m_busy && m_age == 1) ? m_b : 0);
            chk("res_valid", int'(res_valid), (m_busy && m_age == 3) ? 1 : 0);
            if (m_busy && m_age == 3) begin
                arith(m_a, m_b, m_sub, e_d, e_o, e_c);
                chk("res_data", int'(res_data), e_d);
                chk("res_id", int'(res_id), m_id);
                chk("res_ovf", int'(res_ovf), e_o);
                chk("res_cy", int'(res_cy), e_c);
            end
            if (e_r0 || e_r1) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_id   = e_r1;
                m_a    = e_r1 ? int'(req1_a) : int'(req0_a);
                m_b    = e_r1 ? int'(req1_b) : int'(req0_b);
                m_sub  = e_r1 ? int'(req1_sub) : int'(req0_sub);
                m_last = m_id;
            end else if (m_busy) begin
                if (m_age < 3) m_age++;
                else if (res_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic drive(input int r, input int a, input int b, input int sub, input bit v);
        if (r == 1) begin
            req1_valid = v; req1_a = 8'(a); req1_b = 8'(b); req1_sub = sub[0];
        end else begin
            req0_valid = v; req0_a = 8'(a); req0_b = 8'(b); req0_sub = sub[0];
        end
    endtask

    // Called at the accept-cycle falling edge; replaces the operands (which must
    // not affect the in-flight op) and waits for the result.
    task automatic finish_op(input int r, input bit keep, input int exp_tc, input int exp_d,
                             input int exp_id, input int exp_o, input int exp_c);
        int acc, n;
        acc = cyc;
        @(posedge clk);
        #2;
        drive(r, 8'h01, 8'h02, 0, keep);
        @(negedge clk);
        chk("lit tc_in in COMP", int'(tc_in), exp_tc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 20);
        chk("lit latency", cyc - acc, 3);
        chk("lit res_data", int'(res_data), exp_d);
        chk("lit res_id", int'(res_id), exp_id);
        chk("lit res_ovf", int'(res_ovf), exp_o);
        chk("lit res_cy", int'(res_cy), exp_c);
        if (res_ready) @(posedge clk);
    endtask

    task automatic wait_accept(input int r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r == 1 ? req1_ready : req0_ready) && n < 50);
        chk("accept seen", int'(r == 1 ? req1_ready : req0_ready), 1);
    endtask

    task automatic op(input int r, input int a, input int b, input int sub, input int exp_d,
                      input int exp_o, input int exp_c);
        @(posedge clk);
        #2;
        drive(r, a, b, sub, 1'b1);
        wait_accept(r);
        finish_op(r, 1'b0, b, exp_d, r, exp_o, exp_c);
    endtask

    initial begin
        int n;
        int snap_d;
        int hs;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Tie-breaking straight after reset: 0, 1, 0 spaced 4 cycles.
        dut_ids.delete();
        dut_cycs.delete();
        @(posedge clk);
        #2;
        drive(0, 8'h11, 8'h22, 0, 1'b1);
        drive(1, 8'h90, 8'h05, 1, 1'b1);
        n = 0;
        while (dut_ids.size() < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("tie grant count", dut_ids.size(), 3);
        if (dut_ids.size() >= 3) begin
            chk("tie grant 0", dut_ids[0], 0);
            chk("tie grant 1", dut_ids[1], 1);
            chk("tie grant 2", dut_ids[2], 0);
            chk("tie spacing a", dut_cycs[1] - dut_cycs[0], 4);
            chk("tie spacing b", dut_cycs[2] - dut_cycs[1], 4);
        end
        repeat (6) @(posedge clk);

        op(0, 8'h05, 8'h03, 0, 8'h08, 0, 0);
        op(1, 8'h00, 8'h80, 1, 8'h80, 1, 1);
        op(0, 8'h7F, 8'h01, 0, 8'h80, 1, 0);
        op(0, 8'hFF, 8'h01, 0, 8'h00, 0, 1);
        op(1, 8'h30, 8'h50, 1, 8'hE0, 0, 1);

        // Backpressure: req0 stays valid while the result is held.
        @(posedge clk);
        #2;
        res_ready = 1'b0;
        drive(0, 8'h10, 8'h20, 1, 1'b1);
        wait_accept(0);
        finish_op(0, 1'b1, 8'h20, 8'hF0, 0, 0, 1);
        snap_d = int'(res_data);
        repeat (5) begin
            @(negedge clk);
            chk("bp res_valid", int'(res_valid), 1);
            chk("bp res_data stable", int'(res_data), snap_d);
            chk("bp req0_ready low", int'(req0_ready), 0);
        end
        @(posedge clk);
        #2 res_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        chk("bp handshake req0_ready", int'(req0_ready), 0);
        wait_accept(0);
        chk("bp accept after handshake", cyc - hs, 1);
        finish_op(0, 1'b0, 8'h02, 8'h03, 0, 0, 0);

        // Reset during ADD, then only req1 valid.
        @(posedge clk);
        #2;
        drive(0, 8'h40, 8'h40, 0, 1'b1);
        wait_accept(0);
        @(posedge clk);
        #2 req0_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        drive(1, 8'h90, 8'h10, 1, 1'b1);
        @(negedge clk);
        chk("lit rst busy", int'(busy), 0);
        chk("lit rst req1_ready", int'(req1_ready), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_accept(1);
        finish_op(1, 1'b0, 8'h10, 8'h80, 1, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
